spi_flash_reader: RTL and testbench

//  SPI-master read engine feeding the SoC's SPI_MISO/SPI_CLK/SPI_CS/SPI_MOSI pins.

---
 rtl/spi_flash_reader.sv | 153 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master that issues READ (0x03) + 24-bit address and streams the
// returned bytes out over a one-deep valid/ready byte buffer.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic             SPI_CLK,
    output logic             SPI_CS,
    output logic             SPI_MOSI,
    input  logic             SPI_MISO
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD, CS_GAP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [31:0]      tx_shift;
    logic [7:0]       rx_shift;
    logic [LEN_W-1:0] bytes_left;
    logic             byte_done;
    logic             last_pending;
    logic             half_done;
    logic             stall;

    assign half_done = (div_cnt == DIV_LAST);
    // Completing a byte while the buffer is still full would overwrite it, so hold SCK low.
    assign stall     = (state == DATA) && (bit_cnt[2:0] == 3'd7) && out_valid && !out_ready;
    assign req_ready = (state == IDLE) && !out_valid;
    assign busy      = (state != IDLE);

    // Sequencer, SCK/CS/MOSI generation, receive shifter and output buffer.
    always_ff @(posedge clk) begin
        if (RST) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= 5'd0;
            tx_shift     <= 32'd0;
            rx_shift     <= 8'd0;
            bytes_left   <= '0;
            byte_done    <= 1'b0;
            last_pending <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 8'd0;
            out_last     <= 1'b0;
            SPI_CLK      <= 1'b0;
            SPI_CS       <= 1'b1;
            SPI_MOSI     <= 1'b0;
        end else begin
            if (byte_done) begin
                out_valid <= 1'b1;
                out_data  <= rx_shift;
                out_last  <= last_pending;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            byte_done <= 1'b0;

            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (req_valid && req_ready && (req_len != '0)) begin
                        state      <= CS_SETUP;
                        SPI_CS     <= 1'b0;
                        tx_shift   <= {8'h03, req_addr};
                        bytes_left <= req_len;
                    end
                end
                CS_SETUP: begin
                    if (half_done) begin
                        state    <= CMD;
                        div_cnt  <= '0;
                        bit_cnt  <= 5'd0;
                        SPI_MOSI <= tx_shift[31];
                        tx_shift <= {tx_shift[30:0], 1'b0};
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                CMD, ADDR, DATA: begin
                    if (!half_done) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else if (!SPI_CLK) begin
                        if (!stall) begin
                            SPI_CLK <= 1'b1;
                            div_cnt <= '0;
                            if (state == DATA) begin
                                rx_shift <= {rx_shift[6:0], SPI_MISO};
                                if (bit_cnt[2:0] == 3'd7) begin
                                    byte_done    <= 1'b1;
                                    last_pending <= (bytes_left == LEN_W'(1));
                                    bytes_left   <= bytes_left - LEN_W'(1);
                                end
                            end
                        end
                    end else begin
                        // Falling edge: the shifter is empty after the address, so MOSI idles low in DATA.
                        SPI_CLK  <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= bit_cnt + 5'd1;
                        SPI_MOSI <= tx_shift[31];
                        tx_shift <= {tx_shift[30:0], 1'b0};
                        if ((state == CMD) && (bit_cnt == 5'd7)) begin
                            state <= ADDR;
                        end else if ((state == ADDR) && (bit_cnt == 5'd31)) begin
                            state <= DATA;
                        end else if ((state == DATA) && (bit_cnt[2:0] == 3'd7) &&
                                     (bytes_left == '0)) begin
                            state <= CS_HOLD;
                        end
                    end
                end
                CS_HOLD: begin
                    if (half_done) begin
                        state   <= CS_GAP;
                        SPI_CS  <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                CS_GAP: begin
                    if (half_done) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    SPI_CS <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench: two engines (CLK_DIV=2 and CLK_DIV=1) each talking to a
// behavioural mode-0 flash model, with table-driven read vectors.
module tb_spi_flash_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [23:0] req_addr = 24'd0;
    logic [15:0] req_len = 16'd0;
    logic        req_valid0 = 1'b0, out_ready0 = 1'b1, miso0 = 1'b0;
    logic        req_ready0, out_valid0, out_last0, busy0, sck0, cs0, mosi0;
    logic [7:0]  out_data0;
    logic        req_valid1 = 1'b0, out_ready1 = 1'b1, miso1 = 1'b0;
    logic        req_ready1, out_valid1, out_last1, busy1, sck1, cs1, mosi1;
    logic [7:0]  out_data1;

    int checks = 0;
    int failures = 0;

    spi_flash_reader #(.CLK_DIV(2), .LEN_W(16)) dut0 (
        .clk(clk), .RST(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_len(req_len), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_data(out_data0), .out_last(out_last0),
        .busy(busy0), .SPI_CLK(sck0), .SPI_CS(cs0), .SPI_MOSI(mosi0), .SPI_MISO(miso0));

    spi_flash_reader #(.CLK_DIV(1), .LEN_W(16)) dut1 (
        .clk(clk), .RST(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .req_len(req_len), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1),
        .busy(busy1), .SPI_CLK(sck1), .SPI_CS(cs1), .SPI_MOSI(mosi1), .SPI_MISO(miso1));

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012345: flash_byte = 8'hA5;
            24'h012346: flash_byte = 8'h3C;
            default:    flash_byte = a[7:0] ^ a[15:8] ^ 8'h96;
        endcase
    endfunction

    // Flash models: header shifted in on SCK rise, data driven on SCK fall.
    logic [31:0] hdr0 = 32'd0, hdr1 = 32'd0;
    int bits0 = 0, rises0 = 0, bits1 = 0, rises1 = 0;
    always @(posedge sck0 or posedge cs0) begin
        if (cs0) bits0 <= 0;
        else begin
            if (bits0 < 32) hdr0 <= {hdr0[30:0], mosi0};
            bits0  <= bits0 + 1;
            rises0 <= rises0 + 1;
        end
    end
    always @(negedge sck0) begin : drv0
        logic [7:0] b;
        if (!cs0 && bits0 >= 32) begin
            b = flash_byte(hdr0[23:0] + 24'((bits0 - 32) / 8));
            miso0 <= b[7 - ((bits0 - 32) % 8)];
        end
    end
    always @(posedge sck1 or posedge cs1) begin
        if (cs1) bits1 <= 0;
        else begin
            if (bits1 < 32) hdr1 <= {hdr1[30:0], mosi1};
            bits1  <= bits1 + 1;
            rises1 <= rises1 + 1;
        end
    end
    always @(negedge sck1) begin : drv1
        logic [7:0] b;
        if (!cs1 && bits1 >= 32) begin
            b = flash_byte(hdr1[23:0] + 24'((bits1 - 32) / 8));
            miso1 <= b[7 - ((bits1 - 32) % 8)];
        end
    end

    // Monitors sampled on the falling clk edge.
    logic [8:0] got0 [64];
    logic [8:0] got1 [16];
    int n0 = 0, n1 = 0, cslow0 = 0, cslow1 = 0, gap0 = 0, gap1 = 0;
    int lowrun0 = 0, maxlow0 = 0, csrise0 = 0, toggles1 = 0, ovseen0 = 0;
    logic clr0 = 1'b0, sck1_prev = 1'b0;
    always @(negedge clk) begin : mon0
        int nxt;
        nxt = (!cs0 && !sck0) ? lowrun0 + 1 : 0;
        lowrun0 <= nxt;
        if (clr0) maxlow0 <= 0;
        else if (nxt > maxlow0) maxlow0 <= nxt;
        if (!cs0) cslow0 <= cslow0 + 1;
        if (cs0 && busy0) gap0 <= gap0 + 1;
        if (out_valid0) ovseen0 <= ovseen0 + 1;
        if (out_valid0 && out_ready0) begin
            got0[n0 % 64] <= {out_last0, out_data0};
            n0 <= n0 + 1;
        end
    end
    always @(negedge clk) begin
        sck1_prev <= sck1;
        if (!cs1) cslow1 <= cslow1 + 1;
        if (!cs1 && (sck1 != sck1_prev)) toggles1 <= toggles1 + 1;
        if (cs1 && busy1) gap1 <= gap1 + 1;
        if (out_valid1 && out_ready1) begin
            got1[n1 % 16] <= {out_last1, out_data1};
            n1 <= n1 + 1;
        end
    end
    always @(posedge cs0) csrise0 <= csrise0 + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] len;
        logic        stall;
        logic [31:0] bytes;
    } vec_t;
    vec_t vecs [4];

    task automatic run0(input vec_t v, input int idx);
        int bn, br, bcs, bgap, bcr, cyc, hold;
        logic [7:0] eb;
        cyc = 0;
        while (!req_ready0 && cyc < 500) begin tick(); cyc++; end
        chk($sformatf("v%0d ready", idx), {31'd0, req_ready0}, 32'd1);
        bn = n0; br = rises0; bcs = cslow0; bgap = gap0; bcr = csrise0;
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        out_ready0 = !v.stall;
        req_addr = v.addr; req_len = v.len; req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        cyc = 0; hold = 0;
        while ((busy0 || (n0 - bn) < int'(v.len)) && cyc < 3000) begin
            if (out_valid0 && !out_ready0) hold++;
            if (hold >= 50) out_ready0 = 1'b1;
            tick();
            cyc++;
        end
        out_ready0 = 1'b1;
        chk($sformatf("v%0d timeout", idx), {31'd0, cyc < 3000}, 32'd1);
        chk($sformatf("v%0d count", idx), n0 - bn, 32'(v.len));
        for (int i = 0; i < int'(v.len); i++) begin
            eb = v.bytes[31 - 8*i -: 8];
            chk($sformatf("v%0d byte%0d", idx, i), {23'd0, got0[(bn + i) % 64]},
                {23'd0, (i == int'(v.len) - 1), eb});
        end
        chk($sformatf("v%0d header", idx), hdr0, {8'h03, v.addr});
        chk($sformatf("v%0d sck_rises", idx), rises0 - br, 32 + 8 * int'(v.len));
        chk($sformatf("v%0d cs_deselects", idx), csrise0 - bcr, 32'd1);
        chk($sformatf("v%0d cs_gap", idx), gap0 - bgap, 32'd2);
        if (v.stall) begin
            chk($sformatf("v%0d stall_seen", idx), {31'd0, maxlow0 >= 10}, 32'd1);
        end else begin
            chk($sformatf("v%0d cs_low_cycles", idx), cslow0 - bcs, 4 + (32 + 8 * int'(v.len)) * 4);
            chk($sformatf("v%0d no_stall", idx), {31'd0, maxlow0 <= 4}, 32'd1);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bn, bcs, cyc, busy_seen, bov, br, b1n, b1r, b1cs, b1g, b1t;
        vecs[0] = '{24'h012345, 16'd2, 1'b0, 32'hA53C_0000};
        vecs[1] = '{24'h000010, 16'd1, 1'b0, 32'h8600_0000};
        vecs[2] = '{24'hFFFFFF, 16'd3, 1'b0, 32'h9696_9700};
        vecs[3] = '{24'h00AB20, 16'd4, 1'b1, 32'h1D1C_1F1E};

        // Reset held three cycles.
        rst = 1'b1;
        repeat (3) tick();
        chk("rst cs", {31'd0, cs0}, 32'd1);
        chk("rst sck", {31'd0, sck0}, 32'd0);
        chk("rst mosi", {31'd0, mosi0}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst out_data", {24'd0, out_data0}, 32'd0);
        chk("rst out_last", {31'd0, out_last0}, 32'd0);
        chk("rst busy", {31'd0, busy0}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready0}, 32'd1);
        chk("rst cs1", {31'd0, cs1}, 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run0(vecs[i], i);

        // Zero-length request: accepted but no bus activity.
        bn = n0; bcs = cslow0; bov = ovseen0; busy_seen = 0;
        req_addr = 24'h001000; req_len = 16'd0; req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy0) busy_seen++;
            tick();
        end
        chk("len0 busy", busy_seen, 32'd0);
        chk("len0 cs_low", cslow0 - bcs, 32'd0);
        chk("len0 out_valid", ovseen0 - bov, 32'd0);
        chk("len0 req_ready", {31'd0, req_ready0}, 32'd1);

        // Reset during the address phase aborts the transfer.
        bn = n0; br = rises0; bov = ovseen0;
        req_addr = 24'h012345; req_len = 16'd2; req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        cyc = 0;
        while ((rises0 - br) < 12 && cyc < 500) begin tick(); cyc++; end
        chk("abort reach_addr", {31'd0, cyc < 500}, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort cs", {31'd0, cs0}, 32'd1);
        chk("abort sck", {31'd0, sck0}, 32'd0);
        chk("abort busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;
        repeat (60) tick();
        chk("abort no_bytes", n0 - bn, 32'd0);
        chk("abort no_valid", ovseen0 - bov, 32'd0);
        run0(vecs[0], 4);

        // CLK_DIV=1 engine: SCK toggles every clk, one-cycle CS gap.
        b1n = n1; b1r = rises1; b1cs = cslow1; b1g = gap1; b1t = toggles1;
        req_addr = 24'h000010; req_len = 16'd1; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        cyc = 0;
        while ((busy1 || n1 == b1n) && cyc < 1000) begin tick(); cyc++; end
        chk("div1 timeout", {31'd0, cyc < 1000}, 32'd1);
        chk("div1 count", n1 - b1n, 32'd1);
        chk("div1 byte", {23'd0, got1[b1n % 16]}, {23'd0, 1'b1, 8'h86});
        chk("div1 header", hdr1, 32'h0300_0010);
        chk("div1 sck_rises", rises1 - b1r, 32'd40);
        chk("div1 cs_low_cycles", cslow1 - b1cs, 32'd82);
        chk("div1 sck_toggles", toggles1 - b1t, 32'd80);
        chk("div1 cs_gap", gap1 - b1g, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
